// File: rtl/bus_arb_pkg.sv
// Shared definitions for the tristate bus arbiter: controller states and a
// constant-friendly ceiling-log2 helper used for index and counter widths.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester found scanning from ptr
// upward, wrapping modulo NSRC.
module rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NSRC  = 4,
  localparam int PTR_W = clog2(NSRC)
) (
  input  logic [NSRC-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             any_req
);

  // Scanning from the far end lets the nearest requester overwrite the rest,
  // so no early loop exit is needed.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      int               idx;
      logic [PTR_W-1:0] sel;
      idx = int'(ptr) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      sel = PTR_W'(idx);
      if (req[sel]) begin
        winner  = sel;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tribuf.sv
// Single-bit tristate driver: passes a onto y when oe is high, otherwise high-Z.
module tribuf (
  input  logic a,
  input  logic oe,
  output wire  y
);

  assign y = oe ? a : 1'bz;

endmodule

// File: rtl/tribuf_bus_arb.sv
// Round-robin arbiter driving NSRC sources onto one registered tristate bus,
// with burst limiting and a guaranteed high-Z turnaround between owners.
module tribuf_bus_arb
  import bus_arb_pkg::*;
#(
  parameter  int WIDTH       = 16,
  parameter  int NSRC        = 4,
  parameter  int TURN_CYCLES = 1,
  parameter  int MAX_BURST   = 8,
  localparam int PTR_W       = clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC-1:0]       src_req,
  input  logic [NSRC*WIDTH-1:0] src_data,
  output logic [NSRC-1:0]       src_ack,
  output wire  [WIDTH-1:0]      bus,
  output logic                  bus_oe,
  output logic [PTR_W-1:0]      owner
);

  localparam int BURST_W = clog2(MAX_BURST + 1);
  localparam int TURN_W  = clog2(TURN_CYCLES + 1);

  state_e             state_q, state_d;
  logic               oe_q, oe_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [TURN_W-1:0]  turn_cnt_q, turn_cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;

  logic [NSRC-1:0]    ack_c;
  logic [WIDTH-1:0]   data_arr [NSRC];
  logic [PTR_W-1:0]   winner;
  logic               any_req;
  logic               others_req;
  logic               arb_now;

  for (genvar i = 0; i < NSRC; i++) begin : g_unpack
    assign data_arr[i] = src_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(.NSRC(NSRC)) u_rr (
    .req     (src_req),
    .ptr     (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign others_req = |(src_req & ~(NSRC'(1) << owner_q));

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    oe_d        = oe_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    out_d       = out_q;
    ack_c       = '0;
    arb_now     = 1'b0;

    unique case (state_q)
      ST_IDLE: arb_now = 1'b1;
      ST_DRIVE: begin
        if (src_req[owner_q] &&
            (burst_cnt_q < BURST_W'(MAX_BURST) || !others_req)) begin
          ack_c[owner_q] = 1'b1;
          out_d          = data_arr[owner_q];
          burst_cnt_d    = (burst_cnt_q == BURST_W'(MAX_BURST)) ? BURST_W'(1)
                                                                : burst_cnt_q + BURST_W'(1);
        end else begin
          oe_d       = 1'b0;
          turn_cnt_d = TURN_W'(1);
          state_d    = ST_TURN;
        end
      end
      ST_TURN: begin
        if (turn_cnt_q < TURN_W'(TURN_CYCLES)) turn_cnt_d = turn_cnt_q + TURN_W'(1);
        else                                   arb_now    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (arb_now) begin
      if (any_req) begin
        ack_c[winner] = 1'b1;
        out_d         = data_arr[winner];
        oe_d          = 1'b1;
        owner_d       = winner;
        rr_ptr_d      = (winner == PTR_W'(NSRC - 1)) ? '0 : winner + PTR_W'(1);
        burst_cnt_d   = BURST_W'(1);
        state_d       = ST_DRIVE;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      oe_q        <= 1'b0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      turn_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      oe_q        <= oe_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
    end
  end

  // NOTE: the data register is left out of reset; it is only visible while
  // oe_q is set, and oe_q is always loaded together with fresh data.
  always_ff @(posedge clk) begin
    out_q <= out_d;
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bus
    tribuf u_tribuf (
      .a  (out_q[b]),
      .oe (oe_q),
      .y  (bus[b])
    );
  end

  assign src_ack = rst_n ? ack_c : '0;
  assign bus_oe  = oe_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_tribuf_bus_arb.sv
// Self-checking bench: two arbiters (turnaround 1 and 3) run directed and
// random source traffic against a behavioural bus-ownership model.
module tb_tribuf_bus_arb;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int MB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]  req_a, req_b;
  logic [N*W-1:0] data_a, data_b;
  wire  [N-1:0]  ack_a, ack_b;
  wire  [W-1:0]  bus_a, bus_b;
  wire           oe_a, oe_b;
  wire  [1:0]    own_a, own_b;

  tribuf_bus_arb #(.WIDTH(W), .NSRC(N), .TURN_CYCLES(1), .MAX_BURST(MB)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .src_req(req_a), .src_data(data_a),
    .src_ack(ack_a), .bus(bus_a), .bus_oe(oe_a), .owner(own_a));

  tribuf_bus_arb #(.WIDTH(W), .NSRC(N), .TURN_CYCLES(3), .MAX_BURST(MB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .src_req(req_b), .src_data(data_b),
    .src_ack(ack_b), .bus(bus_b), .bus_oe(oe_b), .owner(own_b));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Source side: words still to send, next word, increment between words.
  int          pend [2][N];
  logic [W-1:0] nxt [2][N];
  logic [W-1:0] inc [2][N];
  bit          drop_en = 1'b0;

  // Model: who owns the bus, the word shown, run length, Z cycles left
  // before the next arbitration, and the round-robin start point.
  int          turn_c [2] = '{1, 3};
  bit          m_busy  [2];
  bit          m_fresh [2];
  int          m_owner [2];
  int          m_ptr   [2];
  int          m_run   [2];
  int          m_gap   [2];
  logic [W-1:0] m_word [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_cycle(input int l, input logic [N-1:0] rq, input logic [N*W-1:0] dt,
                             input logic rst_v, output logic [N-1:0] ack);
    bit found;
    ack = '0;
    if (!rst_v) begin
      m_busy[l] = 1'b0; m_fresh[l] = 1'b1; m_owner[l] = 0;
      m_ptr[l] = 0; m_run[l] = 0; m_gap[l] = 0;
      return;
    end
    if (m_busy[l]) begin
      bit others;
      others = (rq & ~(4'b0001 << m_owner[l])) != 4'b0000;
      if (rq[m_owner[l]] && (m_run[l] < MB || !others)) begin
        ack[m_owner[l]] = 1'b1;
        m_word[l] = dt[m_owner[l]*W +: W];
        m_run[l]  = (m_run[l] % MB) + 1;
      end else begin
        m_busy[l] = 1'b0;
        m_gap[l]  = turn_c[l] - 1;
      end
    end else if (m_gap[l] > 0) begin
      m_gap[l]--;
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr[l] + k) % N;
        if (!found && rq[i]) begin
          found = 1'b1;
          ack[i] = 1'b1;
          m_busy[l] = 1'b1; m_fresh[l] = 1'b0;
          m_owner[l] = i; m_word[l] = dt[i*W +: W];
          m_ptr[l] = (i + 1) % N; m_run[l] = 1;
        end
      end
    end
  endtask

  task automatic step(input logic rst_v);
    logic [N-1:0]   rq [2];
    logic [N*W-1:0] dt [2];
    logic [N-1:0]   exp_ack;
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < N; i++) begin
        rq[l][i] = (pend[l][i] > 0) && !(drop_en && $urandom_range(0, 3) == 0);
        dt[l][i*W +: W] = nxt[l][i];
      end
    req_a = rq[0]; data_a = dt[0];
    req_b = rq[1]; data_b = dt[1];
    rst_n = rst_v;
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      logic          oe_v;
      logic [W-1:0]  bus_v;
      logic [1:0]    own_v;
      logic [N-1:0]  ack_v;
      oe_v  = (l == 0) ? oe_a  : oe_b;
      bus_v = (l == 0) ? bus_a : bus_b;
      own_v = (l == 0) ? own_a : own_b;
      ack_v = (l == 0) ? ack_a : ack_b;
      check($sformatf("oe l%0d c%0d", l, cyc), 32'(oe_v), 32'(m_busy[l]));
      if (m_busy[l]) begin
        check($sformatf("bus l%0d c%0d", l, cyc), 32'(bus_v), 32'(m_word[l]));
        check($sformatf("owner l%0d c%0d", l, cyc), 32'(own_v), 32'(m_owner[l]));
      end else if (m_fresh[l]) begin
        check($sformatf("owner_rst l%0d c%0d", l, cyc), 32'(own_v), 32'd0);
      end
      model_cycle(l, rq[l], dt[l], rst_v, exp_ack);
      check($sformatf("ack l%0d c%0d", l, cyc), 32'(ack_v), 32'(exp_ack));
      for (int i = 0; i < N; i++)
        if (exp_ack[i]) begin
          pend[l][i]--;
          nxt[l][i] = nxt[l][i] + inc[l][i];
        end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load(input int i, input int cnt, input logic [W-1:0] first, input logic [W-1:0] incr);
    for (int l = 0; l < 2; l++) begin
      pend[l][i] = cnt; nxt[l][i] = first; inc[l][i] = incr;
    end
  endtask

  task automatic clear_all();
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < N; i++) pend[l][i] = 0;
  endtask

  function automatic bit quiet();
    bit q;
    q = 1'b1;
    for (int l = 0; l < 2; l++) begin
      if (m_busy[l] || m_gap[l] != 0) q = 1'b0;
      for (int i = 0; i < N; i++) if (pend[l][i] != 0) q = 1'b0;
    end
    return q;
  endfunction

  task automatic drain(input string tag);
    int c;
    c = 0;
    while (!quiet() && c < 400) begin
      step(1'b1);
      c++;
    end
    check({"drain ", tag}, 32'(quiet()), 32'd1);
    step(1'b1);
    step(1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0; req_b = '0; data_a = '0; data_b = '0;
    clear_all();
    @(posedge clk);
    #1;

    // Reset held for three cycles with every source requesting.
    for (int i = 0; i < N; i++) load(i, 5, W'(16'hF000 + i), 16'h0001);
    repeat (3) step(1'b0);
    clear_all();
    step(1'b1);

    // Single three-word burst from source 0.
    load(0, 3, 16'h1111, 16'h1111);
    drain("single");

    // Sources 1 and 2 compete continuously from reset.
    step(1'b0);
    load(1, 60, 16'h1000, 16'h0001);
    load(2, 60, 16'h2000, 16'h0001);
    repeat (45) step(1'b1);
    clear_all();
    drain("fair");

    // Turnaround between two owners with two words each.
    load(0, 2, 16'h0A00, 16'h0001);
    load(3, 2, 16'h3A00, 16'h0001);
    drain("turn");

    // Lone requester exceeding the burst limit.
    load(2, 20, 16'h2B00, 16'h0001);
    drain("lone");

    // Reset after the fourth of six words is acked.
    load(0, 6, 16'hA001, 16'h0001);
    for (int c = 0; c < 20 && pend[0][0] > 2; c++) step(1'b1);
    check("midburst_acked", 32'(pend[0][0]), 32'd2);
    step(1'b0);
    drain("midreset");

    // Random traffic with occasional request drops and resets.
    drop_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        load(i, $urandom_range(0, 12), W'($urandom), W'($urandom_range(1, 255)));
      for (int c = 0; c < 30; c++) step(($urandom_range(0, 40) == 0) ? 1'b0 : 1'b1);
      drain($sformatf("rand%0d", r));
    end
    drop_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
